// File: rtl/digit_gen_seq.sv
// digit_gen_seq: sequential target-digit generator.
// Takes a pattern of NDIG digits, where 0 marks a free digit and any nonzero value is fixed.
// Each free digit is filled from a free-running 16-bit Galois LFSR by rejection sampling.
// A filled digit lies in 1..RADIX-1 and, when UNIQUE is set, differs from every other digit.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   request, sampled only while idle
//   pattern NDIG*DW digit pattern, latched on an accepted start
//   busy    high while the request is being checked or filled
//   done    one-cycle completion pulse
//   err     request failed; held until the next accepted start
//   result  generated digits; only updated on success
module digit_gen_seq #(
    parameter int unsigned NDIG    = 4,
    parameter int unsigned DW      = 4,
    parameter int unsigned RADIX   = 10,
    parameter int unsigned UNIQUE  = 1,
    parameter int unsigned MAX_TRY = 255,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NDIG*DW-1:0]   pattern,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [NDIG*DW-1:0]   result
);

    localparam int unsigned IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned TW       = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [DW:0] RADIX_W  = RADIX[DW:0];
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRY - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StFill, StDone} state_t;

    state_t              state_q;
    logic [15:0]         lfsr_q;
    logic [IW-1:0]       idx_q;
    logic [TW-1:0]       try_q;
    logic [NDIG*DW-1:0]  work_q;

    logic [15:0]         lfsr_nxt;
    logic [DW-1:0]       cand;
    logic [DW-1:0]       cur_digit;
    logic                cur_fixed;
    logic                cand_ok;
    logic                pat_bad;
    logic [NDIG*DW-1:0]  work_nxt;

    always_comb begin
        lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end

    assign cand = lfsr_q[DW-1:0];

    // Pattern validity, evaluated on the latched pattern during CHECK.
    always_comb begin
        pat_bad = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if ({1'b0, work_q[i*DW +: DW]} >= RADIX_W) begin
                pat_bad = 1'b1;
            end
            if (UNIQUE != 0) begin
                for (int j = i + 1; j < int'(NDIG); j++) begin
                    if (work_q[i*DW +: DW] != '0 && work_q[i*DW +: DW] == work_q[j*DW +: DW]) begin
                        pat_bad = 1'b1;
                    end
                end
            end
        end
        // Not enough distinct nonzero values to fill every digit.
        if (UNIQUE != 0 && NDIG + 1 > RADIX) begin
            pat_bad = 1'b1;
        end
    end

    // Candidate test. Free digits still hold 0 in the work register and a
    // candidate is never 0, so comparing against every slot is safe.
    always_comb begin
        cur_digit = work_q[32'(idx_q)*DW +: DW];
        cur_fixed = (cur_digit != '0);
        cand_ok   = (cand != '0) && ({1'b0, cand} < RADIX_W);
        if (UNIQUE != 0) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (work_q[i*DW +: DW] == cand) begin
                    cand_ok = 1'b0;
                end
            end
        end
        work_nxt = work_q;
        if (!cur_fixed) begin
            work_nxt[32'(idx_q)*DW +: DW] = cand;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            lfsr_q  <= SEED_EFF;
            idx_q   <= '0;
            try_q   <= '0;
            work_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            lfsr_q <= lfsr_nxt;
            done   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        work_q  <= pattern;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (pat_bad) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= '0;
                        try_q   <= '0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (cur_fixed || cand_ok) begin
                        work_q <= work_nxt;
                        try_q  <= '0;
                        if (idx_q == LAST_IDX) begin
                            result  <= work_nxt;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (try_q == LAST_TRY) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        try_q <= try_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_gen_seq.sv
module tb_digit_gen_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start   [4];
    logic [15:0] pat     [4];
    logic        busy    [4];
    logic        done    [4];
    logic        err     [4];
    logic [15:0] res     [4];
    logic [15:0] prev_res[4];
    logic [15:0] m_lfsr;

    int checks = 0;
    int errors = 0;

    // u0 default, u1 repeats allowed, u2 radix 4 (always infeasible), u3 tiny retry budget
    digit_gen_seq #(.NDIG(4), .DW(4), .RADIX(10), .UNIQUE(1), .MAX_TRY(255), .SEED(16'hACE1)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .pattern(pat[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .result(res[0]));
    digit_gen_seq #(.NDIG(4), .DW(4), .RADIX(10), .UNIQUE(0), .MAX_TRY(255), .SEED(16'hACE1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .pattern(pat[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .result(res[1]));
    digit_gen_seq #(.NDIG(4), .DW(4), .RADIX(4), .UNIQUE(1), .MAX_TRY(255), .SEED(16'hACE1)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .pattern(pat[2]),
        .busy(busy[2]), .done(done[2]), .err(err[2]), .result(res[2]));
    digit_gen_seq #(.NDIG(4), .DW(4), .RADIX(10), .UNIQUE(1), .MAX_TRY(2), .SEED(16'hACE1)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .pattern(pat[3]),
        .busy(busy[3]), .done(done[3]), .err(err[3]), .result(res[3]));

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Reference random source: the generator's LFSR as a plain sequence.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= lstep(m_lfsr);
    end

    function automatic int p_radix(input int k); return (k == 2) ? 4 : 10; endfunction
    function automatic bit p_uniq(input int k); return (k == 1) ? 1'b0 : 1'b1; endfunction
    function automatic int p_max(input int k); return (k == 3) ? 2 : 255; endfunction

    // Draws candidates from the sequence starting at l0 (LFSR value just before the
    // accepting edge); one decision per edge, first decision two edges later.
    function automatic void predict(input int k, input logic [15:0] l0, input logic [15:0] p,
                                    output logic [15:0] r, output int lat, output bit e);
        int rdx = p_radix(k);
        bit u = p_uniq(k);
        int mx = p_max(k);
        bit [15:0] used = '0;
        bit bad = 1'b0;
        logic [15:0] l;
        int d = 0;
        r = p;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int v = int'(p[i*4 +: 4]);
            if (v != 0) begin
                if (v >= rdx) bad = 1'b1;
                if (u && used[v]) bad = 1'b1;
                used[v] = 1'b1;
            end
        end
        if (u && 4 > rdx - 1) bad = 1'b1;
        if (bad) begin
            e = 1'b1;
            lat = 1;
            return;
        end
        l = lstep(lstep(l0));
        for (int i = 0; i < 4 && !e; i++) begin
            if (p[i*4 +: 4] != 4'h0) begin
                d++;
                l = lstep(l);
            end else begin
                int tries = 0;
                bit got = 1'b0;
                while (!got && !e) begin
                    int c = int'(l[3:0]);
                    d++;
                    l = lstep(l);
                    if (c >= 1 && c < rdx && (!u || !used[c])) begin
                        r[i*4 +: 4] = 4'(c);
                        used[c] = 1'b1;
                        got = 1'b1;
                    end else begin
                        tries++;
                        if (tries == mx) e = 1'b1;
                    end
                end
            end
        end
        lat = 1 + d;
    endfunction

    task automatic do_req(input int k, input logic [15:0] p, input bit pulse,
                          output logic [15:0] got, output bit got_err);
        logic [15:0] er, exp_r;
        int el, m;
        bit ee, extra;
        @(negedge clk);
        predict(k, m_lfsr, p, er, el, ee);
        start[k] = 1'b1;
        pat[k] = p;
        @(negedge clk);
        m = 1;
        start[k] = 1'b0;
        pat[k] = 16'($urandom);
        checks++;
        if (busy[k] !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_e0 u%0d got=%b exp=1", k, busy[k]);
        end
        while (done[k] !== 1'b1 && m < 3000) begin
            start[k] = pulse && (m == 2 || m == 3);
            @(negedge clk);
            m++;
        end
        start[k] = 1'b0;
        got = res[k];
        got_err = err[k];
        checks++;
        if (m >= 3000) begin
            errors++;
            $display("FAIL done_timeout u%0d got=no_done exp=done_at_E%0d", k, el);
            return;
        end
        if (m - 1 != el) begin
            errors++;
            $display("FAIL latency u%0d pat=%h got=E%0d exp=E%0d", k, p, m - 1, el);
        end
        checks++;
        if (err[k] !== ee) begin
            errors++;
            $display("FAIL err u%0d pat=%h got=%b exp=%b", k, p, err[k], ee);
        end
        exp_r = ee ? prev_res[k] : er;
        checks++;
        if (res[k] !== exp_r) begin
            errors++;
            $display("FAIL result u%0d pat=%h got=%h exp=%h", k, p, res[k], exp_r);
        end
        checks++;
        if (busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done u%0d got=%b exp=0", k, busy[k]);
        end
        if (!ee) prev_res[k] = er;
        if (pulse) begin
            // start during DONE must be ignored as well
            start[k] = 1'b1;
            @(negedge clk);
            start[k] = 1'b0;
            extra = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (done[k] !== 1'b0 || busy[k] !== 1'b0) extra = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (extra) begin
                errors++;
                $display("FAIL single_done u%0d got=extra_activity exp=idle", k);
            end
        end else begin
            @(negedge clk);
            checks++;
            if (done[k] !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_width u%0d got=%b exp=0", k, done[k]);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy[k] !== 1'b0 || done[k] !== 1'b0 || err[k] !== 1'b0 || res[k] !== 16'h0) begin
                errors++;
                $display("FAIL reset_state u%0d got=%b%b%b/%h exp=000/0000",
                         k, busy[k], done[k], err[k], res[k]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_fixed;
        logic [15:0] g;
        bit ge;
        do_req(0, 16'h1234, 1'b1, g, ge);
        do_req(0, 16'h9876, 1'b0, g, ge);
    endtask

    task automatic test_random_free;
        logic [15:0] g;
        bit ge, bad;
        bit [15:0] seen;
        for (int n = 0; n < 1000; n++) begin
            do_req(0, 16'h0000, 1'b0, g, ge);
            bad = ge;
            seen = '0;
            for (int i = 0; i < 4; i++) begin
                int v = int'(g[i*4 +: 4]);
                if (v < 1 || v > 9 || seen[v]) bad = 1'b1;
                seen[v] = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL free_digits_rule n=%0d got=%h err=%b exp=4_distinct_1to9", n, g, ge);
            end
        end
    endtask

    task automatic test_partial;
        logic [15:0] g;
        bit ge, bad;
        for (int n = 0; n < 50; n++) begin
            do_req(0, 16'h1200, 1'b0, g, ge);
            bad = ge || g[15:8] != 8'h12 || g[7:4] == g[3:0];
            for (int i = 0; i < 2; i++) begin
                if (g[i*4 +: 4] < 4'd3 || g[i*4 +: 4] > 4'd9) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL partial_rule n=%0d got=%h exp=12xy_xy_distinct_3to9", n, g);
            end
        end
    endtask

    task automatic test_check_err;
        logic [15:0] g;
        bit ge;
        do_req(0, 16'h1234, 1'b0, g, ge);
        do_req(0, 16'h1A00, 1'b0, g, ge);
        checks++;
        if (ge !== 1'b1 || g !== 16'h1234) begin
            errors++;
            $display("FAIL range_err got=%b/%h exp=1/1234", ge, g);
        end
        do_req(0, 16'h1100, 1'b0, g, ge);
        do_req(1, 16'h1100, 1'b0, g, ge);
        checks++;
        if (ge !== 1'b0 || g[15:8] !== 8'h11) begin
            errors++;
            $display("FAIL repeat_ok got=%b/%h exp=0/11xx", ge, g);
        end
    endtask

    task automatic test_radix;
        logic [15:0] g;
        bit ge;
        for (int n = 0; n < 10; n++) begin
            do_req(2, (n == 0) ? 16'h0000 : 16'($urandom_range(0, 16'h3333)), n == 1, g, ge);
            checks++;
            if (ge !== 1'b1) begin
                errors++;
                $display("FAIL radix4_err n=%0d got=%b exp=1", n, ge);
            end
        end
    endtask

    task automatic test_maxtry;
        logic [15:0] g;
        bit ge;
        for (int n = 0; n < 60; n++) do_req(3, 16'h0000, 1'b0, g, ge);
    endtask

    task automatic test_mixed;
        logic [15:0] g, p;
        bit ge;
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 4; i++) begin
                p[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            do_req(n % 2, p, 1'b0, g, ge);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] g;
        bit ge;
        @(negedge clk);
        start[0] = 1'b1;
        pat[0] = 16'h0000;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill_busy got=%b exp=1", busy[0]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0 || res[0] !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got=%b%b%b/%h exp=000/0000", busy[0], done[0], err[0], res[0]);
        end
        // start held during reset must not be taken
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        start[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins got=%b exp=0", busy[0]);
        end
        for (int k = 0; k < 4; k++) prev_res[k] = 16'h0;
        do_req(0, 16'h0000, 1'b0, g, ge);
        do_req(0, 16'h0300, 1'b0, g, ge);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            start[k] = 1'b0;
            pat[k] = 16'h0;
            prev_res[k] = 16'h0;
        end
        test_reset;
        test_fixed;
        test_random_free;
        test_partial;
        test_check_err;
        test_radix;
        test_maxtry;
        test_mixed;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
